// File: rtl/inv_mod_pkg.sv
// Shared types and constants for the modular-inverse block.
package inv_mod_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PH1   = 3'd1,
        ST_CORR  = 3'd2,
        ST_NEG   = 3'd3,
        ST_HALVE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic MODE_PLAIN = 1'b0;
    localparam logic MODE_MONT  = 1'b1;

    // Iteration counter must hold values up to 2N.
    function automatic int kw_of(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/inv_mod_halve.sv
// Modular halving: (r + (r odd ? M : 0)) >> 1 on N+1 bits, with r <= M < 2^N.
module inv_mod_halve #(
    parameter int DATA_WIDTH = 256
) (
    input  logic [DATA_WIDTH:0]   r_i,
    input  logic [DATA_WIDTH-1:0] m_i,
    output logic [DATA_WIDTH:0]   r_o
);

    logic [DATA_WIDTH:0] sum;

    assign sum = r_i + (r_i[0] ? {1'b0, m_i} : '0);
    assign r_o = sum >> 1;

endmodule

// File: rtl/inv_mod_gen2.sv
// Kaliski almost-inverse modular inverter with PLAIN / Montgomery output.
// Optional input and gcd checking is enabled by defining INV_MOD_GEN2_ERR_CHK_EN.
//
// state    | meaning
// IDLE     | ready for a request
// PH1      | binary almost-inverse loop, one iteration per cycle
// CORR     | bring r below the modulus
// NEG      | r = M - r, load halving count
// HALVE    | divide r by 2 mod M, count cycles
// DONE     | one-cycle result strobe
module inv_mod_gen2
    import inv_mod_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int KW         = kw_of(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opM,
    input  logic                  mode,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);

    localparam int N = DATA_WIDTH;
    localparam logic [KW-1:0] K_MAX = KW'(2 * N);
    localparam logic [KW-1:0] K_N   = KW'(N);

    state_e        state_q, state_d;
    logic [N:0]    u_q, u_d, v_q, v_d, s_q, s_d, r_q, r_d;
    logic [N-1:0]  m_q, m_d;
    logic          mode_q, mode_d;
    logic [KW-1:0] k_q, k_d, cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          out_err_q, out_err_d;

    logic [N:0]    m_ext, r_half;
    logic [KW-1:0] halve_cnt;
    logic          bad_in, bad_gcd, err_now;

    assign m_ext = {1'b0, m_q};

    inv_mod_halve #(.DATA_WIDTH(N)) u_halve (
        .r_i (r_q),
        .m_i (m_q),
        .r_o (r_half)
    );

    // Guard k < N in MONT so illegal inputs cannot underflow the count.
    always_comb begin
        halve_cnt = k_q;
        if (mode_q == MODE_MONT) begin
            halve_cnt = (k_q >= K_N) ? (k_q - K_N) : '0;
        end
    end

`ifdef INV_MOD_GEN2_ERR_CHK_EN
    always_comb begin
        bad_in  = (opA == '0) || (opA >= opM) || !opM[0];
        bad_gcd = (u_q != (N+1)'(1));
    end
`else
    always_comb begin
        bad_in  = 1'b0;
        bad_gcd = 1'b0;
    end
`endif

    always_comb begin
        state_d     = state_q;
        u_d         = u_q;
        v_d         = v_q;
        s_d         = s_q;
        r_d         = r_q;
        m_d         = m_q;
        mode_d      = mode_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        err_now     = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    m_d    = opM;
                    mode_d = mode;
                    u_d    = {1'b0, opM};
                    v_d    = {1'b0, opA};
                    s_d    = (N+1)'(1);
                    r_d    = '0;
                    k_d    = '0;
                    if (bad_in) begin
                        err_now = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PH1;
                    end
                end
            end
            ST_PH1: begin
                // k == 2N exit only matters for inputs that break the loop bound.
                if ((v_q == '0) || (k_q == K_MAX)) begin
                    if (bad_gcd) begin
                        err_now = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CORR;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                    if (!u_q[0]) begin
                        u_d = u_q >> 1;
                        s_d = s_q << 1;
                    end else if (!v_q[0]) begin
                        v_d = v_q >> 1;
                        r_d = r_q << 1;
                    end else if (u_q > v_q) begin
                        u_d = (u_q - v_q) >> 1;
                        r_d = r_q + s_q;
                        s_d = s_q << 1;
                    end else begin
                        v_d = (v_q - u_q) >> 1;
                        s_d = s_q + r_q;
                        r_d = r_q << 1;
                    end
                end
            end
            ST_CORR: begin
                if (r_q >= m_ext) begin
                    r_d = r_q - m_ext;
                end
                state_d = ST_NEG;
            end
            ST_NEG: begin
                r_d     = m_ext - r_q;
                cnt_d   = halve_cnt;
                state_d = (halve_cnt == '0) ? ST_DONE : ST_HALVE;
            end
            ST_HALVE: begin
                r_d   = r_half;
                cnt_d = cnt_q - KW'(1);
                if (cnt_q == KW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            out_valid_d = 1'b1;
            out_err_d   = err_now;
            out_data_d  = err_now ? '0 : r_d[N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            u_q         <= '0;
            v_q         <= '0;
            s_q         <= '0;
            r_q         <= '0;
            m_q         <= '0;
            mode_q      <= 1'b0;
            k_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            u_q         <= u_d;
            v_q         <= v_d;
            s_q         <= s_d;
            r_q         <= r_d;
            m_q         <= m_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_inv_mod_gen2.sv
// Directed and random checks of inv_mod_gen2 at DATA_WIDTH=8.
module tb_inv_mod_gen2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] opA;
    logic [7:0] opM;
    logic       mode;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_err;

    int checks = 0;
    int errors = 0;

    inv_mod_gen2 #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opM       (opM),
        .mode      (mode),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Brute-force inverse, independent of the binary algorithm in the design.
    function automatic int inv_ref(input int a, input int m, input int md);
        int r;
        r = 0;
        for (int x = 1; x < m; x++) begin
            if (((a * x) % m) == 1) r = x;
        end
        if (md != 0) r = (r * 256) % m;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the DONE cycle.
    task automatic run_req(input logic [7:0] a, input logic [7:0] m, input logic md,
                           input logic [7:0] exp_d, input logic exp_e, input bit chk_d,
                           input bit hold, input string tag, output int lat);
        int  w;
        bit  busy_rdy;
        opA      = a;
        opM      = m;
        mode     = md;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            lat = 99;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold) opA = 8'($urandom_range(1, 250));
        else      in_valid = 1'b0;
        lat = 1;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_rdy = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat_le36"}, 32'(lat <= 36), 32'd1);
        chk({tag, "_busy_ready"}, 32'(busy_rdy), 32'd0);
        chk({tag, "_err"}, 32'(out_err), 32'(exp_e));
        if (chk_d) chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
        @(negedge clk);
        chk({tag, "_strobe"}, 32'(out_valid), 32'd0);
        if (chk_d) chk({tag, "_hold"}, 32'(out_data), 32'(exp_d));
    endtask

    initial begin
        int lat;
        int spur;
        logic [7:0] ra;
        logic       rm;

        rst      = 1'b1;
        in_valid = 1'b0;
        opA      = '0;
        opM      = 8'd251;
        mode     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);

        run_req(8'd3,   8'd251, 1'b0, 8'd84,  1'b0, 1'b1, 1'b0, "a3_plain",   lat);
        run_req(8'd3,   8'd251, 1'b1, 8'd169, 1'b0, 1'b1, 1'b0, "a3_mont",    lat);
        run_req(8'd1,   8'd251, 1'b0, 8'd1,   1'b0, 1'b1, 1'b0, "a1_plain",   lat);
        run_req(8'd1,   8'd251, 1'b1, 8'd5,   1'b0, 1'b1, 1'b0, "a1_mont",    lat);
        run_req(8'd250, 8'd251, 1'b0, 8'd250, 1'b0, 1'b1, 1'b0, "a250_plain", lat);
        run_req(8'd7,   8'd251, 1'b0, 8'd36,  1'b0, 1'b1, 1'b0, "a7_plain",   lat);

`ifdef INV_MOD_GEN2_ERR_CHK_EN
        run_req(8'd5, 8'd255, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "gcd_err", lat);
        run_req(8'd0, 8'd251, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "zero_err", lat);
        chk("zero_err_fast", 32'(lat <= 2), 32'd1);
`else
        run_req(8'd5, 8'd255, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "illegal_bound", lat);
`endif

        // Reset five cycles into a request.
        opA = 8'd3; opM = 8'd251; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_data", 32'(out_data), 32'd0);
        spur = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) spur++;
            @(negedge clk);
        end
        chk("midrst_no_valid", 32'(spur), 32'd0);
        run_req(8'd7, 8'd251, 1'b0, 8'd36, 1'b0, 1'b1, 1'b0, "post_rst_a7", lat);

        // Back-to-back with in_valid held high and garbage operands while busy.
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(1, 250));
            rm = 1'($urandom_range(0, 1));
            run_req(ra, 8'd251, rm, 8'(inv_ref(int'(ra), 251, int'(rm))), 1'b0, 1'b1, 1'b1,
                    $sformatf("b2b%0d_a%0d_m%0d", i, ra, rm), lat);
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
